// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

  localparam int unsigned MAX_CHANNELS = 16;
  localparam int unsigned MIN_WIDTH    = 2;
  localparam int unsigned MAX_WIDTH    = 32;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTRE = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow duty register, compare against the shared counter,
// polarity inversion and the registered output.
module pwm_chan #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             active_i,
  input  logic             pol_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] sd_q, sd_d;
  logic             pwm_q, pwm_d;

  // Next shadow duty and next output level (inactive level unless counter runs).
  always_comb begin
    sd_d  = sd_q;
    pwm_d = pol_i;
    if (load_i) begin
      sd_d = duty_i;
    end
    if (active_i && (cnt_i < sd_q)) begin
      pwm_d = ~pol_i;
    end
  end

  // Shadow duty and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_q  <= '0;
      pwm_q <= 1'b0;
    end else begin
      sd_q  <= sd_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter (edge or centre aligned),
// double-buffered period/duty/mode loaded only at period boundaries, and a
// period-start strobe aligned with the registered channel outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       pol,
  input  logic                      update,
  output logic                      update_pending,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       pwm
);

  if ((CHANNELS == 0) || (CHANNELS > MAX_CHANNELS) ||
      (WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_cfg_err
    $error("pwm_multi: CHANNELS or WIDTH out of range");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic             smode_q, smode_d;
  logic             pend_q, pend_d;
  logic             pstart_q, pstart_d;

  logic             sp_zero_c;
  logic [WIDTH-1:0] last_c;
  logic             boundary_c;
  logic             load_c;
  logic             shadow_load_c;

  // Boundary detection; last count only formed for a non-zero period.
  always_comb begin
    sp_zero_c = (sp_q == '0);
    last_c    = sp_zero_c ? '0 : (sp_q - WIDTH'(1));
    if (sp_zero_c) begin
      boundary_c = 1'b1;
    end else if (smode_q == MODE_EDGE) begin
      boundary_c = (cnt_q == last_c);
    end else begin
      boundary_c = (dir_q == DIR_DOWN) && (cnt_q == '0);
    end
    load_c        = en && boundary_c && (pend_q || update);
    shadow_load_c = !en || load_c;
  end

  // Counter/direction FSM, shadow reload, pending flag and period-start strobe.
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    sp_d     = sp_q;
    smode_d  = smode_q;
    pend_d   = pend_q;
    pstart_d = 1'b0;
    if (!en) begin
      sp_d    = period;
      smode_d = mode;
      cnt_d   = '0;
      dir_d   = DIR_UP;
      pend_d  = 1'b0;
    end else begin
      pstart_d = !sp_zero_c && (cnt_q == '0) && (dir_q == DIR_UP);
      if (load_c) begin
        sp_d    = period;
        smode_d = mode;
        pend_d  = 1'b0;
        cnt_d   = '0;
        dir_d   = DIR_UP;
      end else begin
        pend_d = pend_q || update;
        if (sp_zero_c) begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end else if (smode_q == MODE_EDGE) begin
          dir_d = DIR_UP;
          cnt_d = (cnt_q == last_c) ? '0 : (cnt_q + WIDTH'(1));
        end else if (dir_q == DIR_UP) begin
          if (cnt_q == last_c) begin
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            dir_d = DIR_UP;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      sp_q     <= '0;
      smode_q  <= MODE_EDGE;
      pend_q   <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      sp_q     <= sp_d;
      smode_q  <= smode_d;
      pend_q   <= pend_d;
      pstart_q <= pstart_d;
    end
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
    pwm_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .load_i  (shadow_load_c),
      .active_i(en && !sp_zero_c),
      .pol_i   (pol[i]),
      .duty_i  (duty[i*int'(WIDTH) +: WIDTH]),
      .cnt_i   (cnt_q),
      .pwm_o   (pwm[i])
    );
  end

  assign update_pending = pend_q;
  assign period_start   = pstart_q;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel, parametrised PWM generator. Successor to the single-channel core.
- All CHANNELS outputs share one period counter, so their edges are phase-aligned.
- Adds double-buffered (shadow) period/duty/mode registers that load only at period boundaries, glitch-free.
- Adds edge- or centre-aligned counting, per-channel output polarity and a period-start strobe for ADC triggering/sync.

Parameters:
- CHANNELS, 4: number of PWM outputs, 1..16.
- WIDTH, 16: width of period, duty and counter, 2..32.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable.
- mode  in  1  0 = edge-aligned, 1 = centre-aligned.
- period  in  WIDTH  period value P.
- duty  in  CHANNELS*WIDTH  duty D[i] is slice [i*WIDTH +: WIDTH].
- pol  in  CHANNELS  1 = channel i active-low.
- update  in  1  single-cycle request to load period/duty/mode into the shadows.
- update_pending  out  1  a load request is waiting for a boundary.
- period_start  out  1  one-cycle strobe on the first output cycle of each period.
- pwm  out  CHANNELS  PWM outputs.

Behaviour:
Reset (rst=1 at posedge):
- cnt=0, dir=UP, all shadows=0, update_pending=0, period_start=0, pwm=0.
- rst overrides every other input, including mid-period.

Shadows:
- Shadows sP, sD[i], sMode are what the counter and comparators use.
- en=0: shadows load from the inputs every cycle; cnt=0, dir=UP, update_pending=0, period_start=0, pwm[i]=pol[i] (inactive level).
- en=1: update sets update_pending.
- At a boundary, if update_pending or update is high in that same cycle: load shadows, clear update_pending, and force cnt=0, dir=UP for the next cycle.
- update coinciding with a boundary loads at that boundary.
- pol is live, not shadowed.

Edge mode (sMode=0):
- cnt counts 0..sP-1 and wraps; period is sP cycles.
- Boundary is the cycle where cnt==sP-1.

Centre mode (sMode=1):
- dir=UP: cnt==sP-1 -> dir=DOWN and cnt holds; else cnt+1.
- dir=DOWN: cnt==0 -> dir=UP and cnt holds; else cnt-1.
- Resulting sequence is 0..sP-1, sP-1..0; period is 2*sP cycles.
- Boundary is dir=DOWN with cnt==0.

sP=0 (either mode):
- Counter frozen at 0, every cycle is a boundary, period_start never asserts, pwm[i]=pol[i].

Compare:
- raw[i] = (cnt < sD[i]), unsigned WIDTH-bit compare.
- sD=0 gives always inactive; sD>=sP gives always active.
- Edge mode: exactly sD high cycles per period.
- Centre mode: 2*sD high cycles, centred on cnt=0.

Outputs:
- pwm[i] <= raw[i] ^ pol[i], registered; one cycle latency from cnt.
- period_start is registered from (cnt==0 && dir==UP && first cycle of period) with the same latency, so it aligns with pwm.
- In centre mode period_start is asserted only on the UP-side 0, never on the DOWN-side 0.

Widths:
- No arithmetic wider than WIDTH. sP-1 is evaluated only when sP!=0.

Decomposition:
- Shared package pwm_pkg holds MODE_EDGE=1'b0, MODE_CENTRE=1'b1, DIR_UP/DIR_DOWN, and a max-CHANNELS check constant.
- The top level holds the counter, dir FSM, shadow/update logic and period_start.
- Sub-module pwm_chan holds one channel's shadow duty, compare, polarity XOR and output register; it is generate-instantiated CHANNELS times.

Test Plan:
1. Edge, CHANNELS=4, WIDTH=16: P=10, D={0,3,10,12}, pol=0, en 0->1 -> pwm0 always 0; pwm1 high 3 of every 10 cycles; pwm2 and pwm3 always 1; period_start every 10 cycles, aligned with pwm1 rising.
2. Centre: P=8, D=2 -> period 16; pwm high for 4 consecutive cycles spanning the valley (cnt 1,0,0,1); period_start once per 16 cycles.
3. Shadowing: running P=10 D=3, pulse update mid-period with P=20 D=5 -> update_pending=1 until wrap; current period finishes 10 cycles at D=3; next period is 20 cycles at D=5; update_pending clears at the boundary.
4. Boundary coincidence: update on the cnt==sP-1 cycle -> new values take effect in the very next period; update_pending never observed high.
5. pol=4'b1010 with D=0 on all channels -> pwm=4'b1010 constant. P=0 with en=1 -> counter frozen, no period_start, pwm=pol.
6. Reset mid-period (cnt=5, centre, dir=DOWN): rst for 1 cycle -> pwm=0, period_start=0, shadows 0. After release with en=1 -> outputs at the inactive level (sP=0) until update with P=10 loads.
